ysyx_22040759_ifu: RTL

Instruction fetch unit for the ysyx_22040759 core: owns the fetch PC, drives the instruction RAM read port (address plus enable, with the instruction returned one cycle later), and presents a PC/instruction pair to decode over a valid/ready handshake. A 2-entry buffer absorbs decode back-pressure. Taken branches and jumps redirect the PC and flush any fetched-but-unconsumed instructions.

---
 rtl/ysyx_22040759_ifu.sv | 88 ++++++++
 1 files changed

// File: rtl/ysyx_22040759_ifu.sv
// rtl/ysyx_22040759_ifu.sv - instruction fetch unit with 2-entry skid buffer and redirect flush
module ysyx_22040759_ifu #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [63:0] inst_raddr,
   output logic        i_ram_en,
   input  logic [31:0] inst,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [63:0] if_pc,
   output logic [31:0] if_inst,
   output logic        fetch_fault
);

   logic [63:0] fetch_pc;
   logic [63:0] pend_pc;
   logic        pend;
   logic [63:0] buf_pc   [2];
   logic [31:0] buf_inst [2];
   logic        head;
   logic [1:0]  count;

   logic        has_buf;
   logic        pop;
   logic        bypass;
   logic        buf_pop;
   logic        push;
   logic        tail;
   logic [2:0]  credit;

   always_comb begin
      has_buf     = (count != 2'd0);
      if_valid    = (has_buf | pend) & ~redirect_valid;
      if_pc       = 64'd0;
      if_inst     = 32'd0;
      if (if_valid) begin
         if_pc   = has_buf ? buf_pc[head]   : pend_pc;
         if_inst = has_buf ? buf_inst[head] : inst;
      end
      pop         = if_valid & id_ready;
      bypass      = pop & ~has_buf;
      buf_pop     = pop & has_buf;
      push        = pend & ~bypass;
      tail        = head ^ count[0];
      // Count+pend never exceeds 2, so this cannot underflow.
      credit      = 3'd2 + {2'b00, pop} - {1'b0, count} - {2'b00, pend};
      fetch_fault = (fetch_pc[1:0] != 2'b00) | (fetch_pc == 64'd0);
      i_ram_en    = rst_n & ~redirect_valid & ~fetch_fault & (credit != 3'd0);
      inst_raddr  = fetch_pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         pend_pc  <= 64'd0;
         pend     <= 1'b0;
         head     <= 1'b0;
         count    <= 2'd0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc;
         pend     <= 1'b0;
         head     <= 1'b0;
         count    <= 2'd0;
      end else begin
         if (buf_pop)
            head <= ~head;
         count <= count + {1'b0, push} - {1'b0, buf_pop};
         pend  <= i_ram_en;
         if (i_ram_en) begin
            pend_pc  <= fetch_pc;
            fetch_pc <= fetch_pc + 64'd4;
         end
      end
   end

   // Payload storage needs no reset; count decides what is valid.
   always_ff @(posedge clk) begin
      if (push && !redirect_valid) begin
         buf_pc[tail]   <= pend_pc;
         buf_inst[tail] <= inst;
      end
   end

endmodule
